// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the size/state encodings, lane width and the byte-enable and access-error helpers.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int LANE_W = 8;

    function automatic logic [3:0] byte_en(input size_t sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Word index is compared full-width so high addresses never alias into storage.
    function automatic logic access_err(input size_t sz, input logic [31:0] addr,
                                        input logic [31:0] depth);
        logic err;
        err = ({2'b00, addr[31:2]} >= depth);
        case (sz)
            SZ_HALF: err = err | addr[0];
            SZ_WORD: err = err | (addr[1:0] != 2'b00);
            SZ_ILL:  err = 1'b1;
            default: ;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Little-endian lane steering: read-lane extraction with zero-extension,
// store-data replication and byte-enable generation. Purely combinational.
module mem_lane_unit
    import mem_resp_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] rword_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic [31:0] wrep_o,
    output logic [3:0]  be_o
);

    size_t       sz;
    logic [31:0] sh_b;
    logic [31:0] sh_h;

    assign sz   = size_t'(size_i);
    assign sh_b = rword_i >> {off_i, 3'b000};
    assign sh_h = rword_i >> {off_i[1], 4'b0000};
    assign be_o = byte_en(sz, off_i);

    always_comb begin
        rdata_o = 32'h0;
        wrep_o  = 32'h0;
        case (sz)
            SZ_BYTE: begin
                rdata_o = {24'h0, sh_b[7:0]};
                wrep_o  = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                rdata_o = {16'h0, sh_h[15:0]};
                wrep_o  = {2{wdata_i[15:0]}};
            end
            SZ_WORD: begin
                rdata_o = rword_i;
                wrep_o  = wdata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory end of the datapath load/store interface: latches one request, waits the
// effective latency, then pulses resp_valid with registered data/error. No response backpressure.
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int RD_LAT      = 2,
    parameter int WR_LAT      = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic [1:0]  state
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] RD_CNT = 4'((RD_LAT > 1) ? RD_LAT - 2 : 0);
    localparam logic [3:0] WR_CNT = 4'((WR_LAT > 1) ? WR_LAT - 2 : 0);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic        in_idle;
    logic        cur_we;
    logic [1:0]  cur_size;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic        cur_err;
    logic [AW-1:0] cur_idx;
    logic [31:0] rword;
    logic [31:0] lane_rdata;
    logic [31:0] lane_wrep;
    logic [3:0]  lane_be;
    logic        lat_one;
    logic [3:0]  lat_cnt;
    logic        enter_resp;
    logic        commit_we;

    // A single-cycle access enters RESP on the accept edge, before the latches
    // are loaded, so the live inputs stand in for the latched request in IDLE.
    assign in_idle   = (state_q == IDLE);
    assign cur_we    = in_idle ? req_we    : we_q;
    assign cur_size  = in_idle ? req_size  : size_q;
    assign cur_addr  = in_idle ? req_addr  : addr_q;
    assign cur_wdata = in_idle ? req_wdata : wdata_q;
    assign cur_err   = access_err(size_t'(cur_size), cur_addr, 32'(DEPTH_WORDS));
    assign cur_idx   = cur_addr[AW+1:2];
    assign rword     = mem[cur_idx];

    assign lat_one = cur_err || (cur_we ? (WR_LAT == 1) : (RD_LAT == 1));
    assign lat_cnt = cur_we ? WR_CNT : RD_CNT;

    mem_lane_unit u_lane (
        .size_i  (cur_size),
        .off_i   (cur_addr[1:0]),
        .rword_i (rword),
        .wdata_i (cur_wdata),
        .rdata_o (lane_rdata),
        .wrep_o  (lane_wrep),
        .be_o    (lane_be)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = 32'h0;
        err_d      = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (lat_one) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = lat_cnt;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (enter_resp) begin
            err_d   = cur_err;
            rdata_d = (cur_err || cur_we) ? 32'h0 : lane_rdata;
        end
    end

    assign commit_we = enter_resp && cur_we && !cur_err;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately not reset; a reset only prevents pending commits.
    always_ff @(posedge clock) begin
        if (commit_we) begin
            for (int k = 0; k < 4; k++) begin
                if (lane_be[k]) begin
                    mem[cur_idx][k*LANE_W +: LANE_W] <= lane_wrep[k*LANE_W +: LANE_W];
                end
            end
        end
    end

    assign req_ready  = in_idle;
    assign busy       = !in_idle;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign state      = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one default instance (RD_LAT=2, WR_LAT=1)
// and one with WR_LAT=3 for the reset-during-WAIT case; both share the request inputs.
module tb_data_mem_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        d1_ready, d1_rv, d1_err, d1_busy;
    logic [31:0] d1_rdata;
    logic [1:0]  d1_state;
    logic        d3_ready, d3_rv, d3_err, d3_busy;
    logic [31:0] d3_rdata;
    logic [1:0]  d3_state;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    data_mem_responder #(.DEPTH_WORDS(256), .RD_LAT(2), .WR_LAT(1)) u_dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(d1_ready),
        .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(d1_rv), .resp_rdata(d1_rdata), .resp_err(d1_err),
        .busy(d1_busy), .state(d1_state)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .RD_LAT(2), .WR_LAT(3)) u_dut3 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(d3_ready),
        .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(d3_rv), .resp_rdata(d3_rdata), .resp_err(d3_err),
        .busy(d3_busy), .state(d3_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request on the selected instance; returns data, error and observed latency.
    task automatic do_req(input bit sel3, input logic we, input logic [1:0] sz,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int lat);
        int guard;
        guard = 0;
        do begin
            @(negedge clock);
            guard++;
        end while (!(sel3 ? d3_ready : d1_ready) && guard < 40);
        chk("ready_wait", {31'h0, (sel3 ? d3_ready : d1_ready)}, 32'h1);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = sz;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clock);
        #1 req_valid = 1'b0;
        lat = 0;
        rd  = 32'hx;
        err = 1'bx;
        do begin
            @(negedge clock);
            lat++;
            chk("busy", {31'h0, (sel3 ? d3_busy : d1_busy)}, 32'h1);
        end while (!(sel3 ? d3_rv : d1_rv) && lat < 40);
        rd  = sel3 ? d3_rdata : d1_rdata;
        err = sel3 ? d3_err : d1_err;
        @(negedge clock);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] hs_addr [4];
    logic [31:0] hs_dat  [4];
    logic        hs_err  [4];
    int          hs_lat  [4];

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = 2'd0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;

        // Reset state
        @(negedge clock);
        chk("rst_ready", {31'h0, d1_ready}, 32'h1);
        chk("rst_rv",    {31'h0, d1_rv},    32'h0);
        chk("rst_rdata", d1_rdata,          32'h0);
        chk("rst_err",   {31'h0, d1_err},   32'h0);
        chk("rst_busy",  {31'h0, d1_busy},  32'h0);
        chk("rst_state", {30'h0, d1_state}, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Reset mid-WAIT on the WR_LAT=3 instance
        do_req(1'b1, 1'b1, 2'd2, 32'h10, 32'h0, rd, er, lat);
        chk("pre_st_lat", lat, 32'd3);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
        req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        chk("midwait_state", {30'h0, d3_state}, 32'h1);
        reset = 1'b1;
        #1;
        chk("inrst_ready", {31'h0, d3_ready}, 32'h1);
        chk("inrst_busy",  {31'h0, d3_busy},  32'h0);
        chk("inrst_state", {30'h0, d3_state}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("inrst_rv", {31'h0, d3_rv}, 32'h0);
            if (i == 1) reset = 1'b0;
        end
        do_req(1'b1, 1'b0, 2'd2, 32'h10, 32'h0, rd, er, lat);
        chk("rstld_data", rd, 32'h0);
        chk("rstld_lat",  lat, 32'd2);

        // Word round-trip
        do_req(1'b0, 1'b1, 2'd2, 32'h20, 32'h12345678, rd, er, lat);
        chk("wst_lat", lat, 32'd1);
        chk("wst_err", {31'h0, er}, 32'h0);
        chk("wst_rd",  rd, 32'h0);
        do_req(1'b0, 1'b0, 2'd2, 32'h20, 32'h0, rd, er, lat);
        chk("wld_lat", lat, 32'd2);
        chk("wld_dat", rd, 32'h12345678);
        chk("wld_err", {31'h0, er}, 32'h0);

        // Byte lane merge; upper wdata bits must be ignored
        do_req(1'b0, 1'b1, 2'd0, 32'h22, 32'h555555AB, rd, er, lat);
        chk("bst_err", {31'h0, er}, 32'h0);
        do_req(1'b0, 1'b0, 2'd2, 32'h20, 32'h0, rd, er, lat);
        chk("merge_word", rd, 32'h12AB5678);
        do_req(1'b0, 1'b0, 2'd0, 32'h23, 32'h0, rd, er, lat);
        chk("merge_b3", rd, 32'h00000012);
        do_req(1'b0, 1'b0, 2'd1, 32'h22, 32'h0, rd, er, lat);
        chk("merge_h1", rd, 32'h000012AB);
        do_req(1'b0, 1'b0, 2'd0, 32'h20, 32'h0, rd, er, lat);
        chk("merge_b0", rd, 32'h00000078);
        do_req(1'b0, 1'b0, 2'd1, 32'h20, 32'h0, rd, er, lat);
        chk("merge_h0", rd, 32'h00005678);
        do_req(1'b0, 1'b1, 2'd1, 32'h20, 32'hFFFF9A9B, rd, er, lat);
        do_req(1'b0, 1'b0, 2'd2, 32'h20, 32'h0, rd, er, lat);
        chk("hst_merge", rd, 32'h12AB9A9B);
        do_req(1'b0, 1'b1, 2'd1, 32'h20, 32'h00005678, rd, er, lat);

        // Errors: each L=1, err=1, rdata=0, no storage change
        do_req(1'b0, 1'b0, 2'd1, 32'h21, 32'h0, rd, er, lat);
        chk("e_half_lat", lat, 32'd1);
        chk("e_half_err", {31'h0, er}, 32'h1);
        chk("e_half_rd",  rd, 32'h0);
        do_req(1'b0, 1'b1, 2'd2, 32'h22, 32'hFFFFFFFF, rd, er, lat);
        chk("e_stw_lat", lat, 32'd1);
        chk("e_stw_err", {31'h0, er}, 32'h1);
        do_req(1'b0, 1'b0, 2'd3, 32'h20, 32'h0, rd, er, lat);
        chk("e_sz_lat", lat, 32'd1);
        chk("e_sz_err", {31'h0, er}, 32'h1);
        chk("e_sz_rd",  rd, 32'h0);
        do_req(1'b0, 1'b0, 2'd2, 32'h400, 32'h0, rd, er, lat);
        chk("e_oor_lat", lat, 32'd1);
        chk("e_oor_err", {31'h0, er}, 32'h1);
        chk("e_oor_rd",  rd, 32'h0);
        do_req(1'b0, 1'b1, 2'd2, 32'h80000020, 32'hFFFFFFFF, rd, er, lat);
        chk("e_alias_err", {31'h0, er}, 32'h1);
        do_req(1'b0, 1'b0, 2'd2, 32'h20, 32'h0, rd, er, lat);
        chk("e_unchanged", rd, 32'h12AB5678);
        chk("e_unch_err",  {31'h0, er}, 32'h0);

        // Last legal word
        do_req(1'b0, 1'b1, 2'd2, 32'h3FC, 32'hCAFEF00D, rd, er, lat);
        chk("top_st_err", {31'h0, er}, 32'h0);
        do_req(1'b0, 1'b0, 2'd2, 32'h3FC, 32'h0, rd, er, lat);
        chk("top_ld", rd, 32'hCAFEF00D);

        // Handshake: req_valid held high, address changing every cycle
        hs_addr[0] = 32'h20;  hs_dat[0] = 32'h12AB5678; hs_err[0] = 1'b0; hs_lat[0] = 2;
        hs_addr[1] = 32'h3FC; hs_dat[1] = 32'hCAFEF00D; hs_err[1] = 1'b0; hs_lat[1] = 2;
        hs_addr[2] = 32'h400; hs_dat[2] = 32'h0;        hs_err[2] = 1'b1; hs_lat[2] = 1;
        hs_addr[3] = 32'h22;  hs_dat[3] = 32'h0;        hs_err[3] = 1'b1; hs_lat[3] = 1;
        begin
            int          next_ready;
            int          resp_cyc;
            logic [31:0] pend_d;
            logic        pend_e;
            next_ready = 0;
            resp_cyc   = -1;
            pend_d     = 32'h0;
            pend_e     = 1'b0;
            req_we     = 1'b0;
            req_size   = 2'd2;
            for (int c = 0; c < 30; c++) begin
                if (c > 0) @(negedge clock);
                req_valid = 1'b1;
                req_addr  = hs_addr[c % 4];
                chk("hs_ready", {31'h0, d1_ready}, {31'h0, (c >= next_ready)});
                chk("hs_busy",  {31'h0, d1_busy},  {31'h0, (c < next_ready)});
                if (c == resp_cyc) begin
                    chk("hs_rv",   {31'h0, d1_rv},  32'h1);
                    chk("hs_data", d1_rdata,        pend_d);
                    chk("hs_err",  {31'h0, d1_err}, {31'h0, pend_e});
                end else begin
                    chk("hs_norv", {31'h0, d1_rv}, 32'h0);
                end
                if (c >= next_ready) begin
                    pend_d     = hs_dat[c % 4];
                    pend_e     = hs_err[c % 4];
                    resp_cyc   = c + hs_lat[c % 4];
                    next_ready = c + hs_lat[c % 4] + 1;
                end
            end
            @(negedge clock);
            req_valid = 1'b0;
        end

        repeat (4) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "timeout");
    end

endmodule
